// File: rtl/deg_ascii_parser.sv
// ASCII angle line parser: validates "ddd.ffff<LF|CR>" text and packs it into the
// BCD nibble word plus integer-digit count used by the BCD-to-binary-angle converter.
module deg_ascii_parser #(
  parameter int unsigned MAX_INT_DIGITS  = 3,
  parameter int unsigned MAX_FRAC_DIGITS = 12,
  parameter logic [7:0]  TERM_CHAR       = 8'h0A,
  parameter int unsigned MAX_DEG         = 360
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_data,
  input  logic        i_valid,
  output logic        o_ready,
  output logic [63:0] o_decimal,
  output logic [3:0]  o_frccnt,
  output logic        o_start,
  input  logic        i_finished,
  output logic        o_error,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {ST_INT, ST_FRAC, ST_LAUNCH, ST_WAIT} state_t;

  state_t      state, state_next;
  logic [3:0]  int_cnt, frac_cnt;
  logic [8:0]  int_acc;
  logic        err;
  logic        take, is_digit, is_dot, is_term, line_empty, line_bad;
  logic [3:0]  digit;
  logic [12:0] acc_wide;
  logic [8:0]  acc_next;

  // Handshake: a byte transfers on a rising edge where i_valid && o_ready; when
  // o_ready is low the upstream must hold i_data/i_valid unchanged.
  assign o_ready    = (state == ST_INT) || (state == ST_FRAC);
  assign o_start    = (state == ST_LAUNCH);
  assign dbg_state  = state;
  assign take       = i_valid && o_ready;

  assign is_digit   = (i_data >= 8'h30) && (i_data <= 8'h39);
  assign digit      = i_data[3:0];
  assign is_dot     = (i_data == 8'h2E);
  assign is_term    = (i_data == TERM_CHAR) || (i_data == 8'h0D);
  assign line_empty = (state == ST_INT) && (int_cnt == 4'd0) && !err;
  assign line_bad   = err || (int_acc >= 9'(MAX_DEG));

  // Integer accumulator saturates so out-of-range values stay detectable.
  assign acc_wide   = 13'(int_acc) * 13'd10 + 13'(digit);
  assign acc_next   = (acc_wide > 13'd511) ? 9'd511 : acc_wide[8:0];

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= ST_INT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_INT, ST_FRAC: begin
        if (take) begin
          if (is_term) begin
            if (line_empty || line_bad) state_next = ST_INT;
            else                        state_next = ST_LAUNCH;
          end else if (is_dot && (state == ST_INT)) begin
            state_next = ST_FRAC;
          end
        end
      end
      ST_LAUNCH: state_next = ST_WAIT;
      ST_WAIT:   if (i_finished) state_next = ST_INT;
      default:   state_next = ST_INT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_decimal <= 64'd0;
      o_frccnt  <= 4'd0;
      o_error   <= 1'b0;
      int_cnt   <= 4'd0;
      frac_cnt  <= 4'd0;
      int_acc   <= 9'd0;
      err       <= 1'b0;
    end else begin
      o_error <= 1'b0;
      case (state)
        ST_INT, ST_FRAC: begin
          if (take) begin
            if (is_term) begin
              if (!line_empty) begin
                if (line_bad) begin
                  o_error   <= 1'b1;
                  o_decimal <= 64'd0;
                  int_cnt   <= 4'd0;
                  frac_cnt  <= 4'd0;
                  int_acc   <= 9'd0;
                  err       <= 1'b0;
                end else begin
                  if (state == ST_INT) o_decimal <= {o_decimal[59:0], 4'hA};
                  o_frccnt <= int_cnt;
                end
              end
            end else if (is_digit) begin
              // After an error the rest of the line is consumed but ignored.
              if (!err) begin
                if (state == ST_INT) begin
                  if (int_cnt == 4'(MAX_INT_DIGITS)) begin
                    err <= 1'b1;
                  end else begin
                    o_decimal <= {o_decimal[59:0], digit};
                    int_cnt   <= int_cnt + 4'd1;
                    int_acc   <= acc_next;
                  end
                end else begin
                  if (frac_cnt == 4'(MAX_FRAC_DIGITS)) begin
                    err <= 1'b1;
                  end else begin
                    o_decimal <= {o_decimal[59:0], digit};
                    frac_cnt  <= frac_cnt + 4'd1;
                  end
                end
              end
            end else if (is_dot && (state == ST_INT)) begin
              if (!err) begin
                // A bare leading '.' gets an implicit integer digit 0.
                if (int_cnt == 4'd0) begin
                  o_decimal <= {o_decimal[55:0], 8'h0A};
                  int_cnt   <= 4'd1;
                end else begin
                  o_decimal <= {o_decimal[59:0], 4'hA};
                end
              end
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (i_finished) begin
            o_decimal <= 64'd0;
            int_cnt   <= 4'd0;
            frac_cnt  <= 4'd0;
            int_acc   <= 9'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_deg_ascii_parser.sv
// Randomized scoreboard bench for deg_ascii_parser: a string-level reference model
// predicts launches/errors per line; a monitor pops and compares on o_start/o_error.
module tb_deg_ascii_parser;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic [7:0]  i_data = 8'h00;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [63:0] o_decimal;
  logic [3:0]  o_frccnt;
  logic        o_start;
  logic        i_finished;
  logic        o_error;
  logic [1:0]  dbg_state;
  logic        fin_mon = 1'b0;
  logic        fin_main = 1'b0;

  int          n_vec = 0;
  int          n_fail = 0;
  bit          auto_finish = 1'b1;
  logic [68:0] exp_q[$];     // {is_error, decimal[63:0], frccnt[3:0]}
  logic [7:0]  lq[$];        // current line, last byte is the terminator

  assign i_finished = fin_mon | fin_main;

  deg_ascii_parser dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_data(i_data), .i_valid(i_valid),
    .o_ready(o_ready), .o_decimal(o_decimal), .o_frccnt(o_frccnt),
    .o_start(o_start), .i_finished(i_finished), .o_error(o_error),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 i_clk = ~i_clk;

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_reset();
    chk("rst_ready",   64'(o_ready),   64'd1);
    chk("rst_decimal", o_decimal,      64'd0);
    chk("rst_frccnt",  64'(o_frccnt),  64'd0);
    chk("rst_start",   64'(o_start),   64'd0);
    chk("rst_error",   64'(o_error),   64'd0);
  endtask

  // ---------------- reference model ----------------
  function automatic void model_push();
    int          n;
    int          dots = 0;
    int          val = 0;
    bit          bad = 1'b0;
    bit          in_frac = 1'b0;
    logic [3:0]  id[$];
    logic [3:0]  fd[$];
    logic [63:0] dec = 64'd0;
    logic [7:0]  c;
    n = lq.size() - 1;
    if (n <= 0) return;
    for (int i = 0; i < n; i++) begin
      c = lq[i];
      if (c >= 8'h30 && c <= 8'h39) begin
        if (in_frac) fd.push_back(c[3:0]);
        else         id.push_back(c[3:0]);
      end else if (c == 8'h2E) begin
        dots++;
        in_frac = 1'b1;
      end else begin
        bad = 1'b1;
      end
    end
    if (id.size() > 3 || fd.size() > 12 || dots > 1) bad = 1'b1;
    if (!bad) begin
      foreach (id[i]) val = val * 10 + int'(id[i]);
      if (val >= 360) bad = 1'b1;
    end
    if (bad) begin
      exp_q.push_back({1'b1, 64'd0, 4'd0});
    end else begin
      if (id.size() == 0) id.push_back(4'd0);
      foreach (id[i]) dec = (dec << 4) | 64'(id[i]);
      dec = (dec << 4) | 64'hA;
      foreach (fd[i]) dec = (dec << 4) | 64'(fd[i]);
      exp_q.push_back({1'b0, dec, 4'(id.size())});
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    i_data  = b;
    i_valid = 1'b1;
    while (!o_ready && waited < 500) begin
      @(negedge i_clk);
      waited++;
    end
    if (!o_ready) begin
      n_vec++;
      n_fail++;
      $display("FAIL send_timeout: o_ready stayed 0 for %0d cycles, expected 1", waited);
    end
    @(negedge i_clk);
    i_valid = 1'b0;
  endtask

  task automatic send_line(input bit use_model);
    if (use_model) model_push();
    foreach (lq[i]) begin
      repeat ($urandom_range(0, 2)) @(negedge i_clk);
      send_byte(lq[i]);
    end
  endtask

  task automatic send_str(input string s);
    lq.delete();
    for (int i = 0; i < s.len(); i++) lq.push_back(s[i]);
    send_line(1'b1);
  endtask

  task automatic gen_line();
    int         ni;
    int         nf;
    logic [7:0] junk[4];
    junk = '{8'h61, 8'h20, 8'h2F, 8'h3A};
    lq.delete();
    ni = ($urandom_range(0, 9) < 8) ? $urandom_range(1, 3) : $urandom_range(0, 4);
    for (int i = 0; i < ni; i++) begin
      if (ni == 3 && i == 0) lq.push_back(8'(8'h30 + $urandom_range(0, 3)));
      else                   lq.push_back(8'(8'h30 + $urandom_range(0, 9)));
    end
    if ($urandom_range(0, 3) != 0) begin
      lq.push_back(8'h2E);
      nf = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 6) : $urandom_range(11, 13);
      for (int i = 0; i < nf; i++) lq.push_back(8'(8'h30 + $urandom_range(0, 9)));
    end
    if ($urandom_range(0, 7) == 0)
      lq.insert($urandom_range(0, lq.size()),
                ($urandom_range(0, 4) == 0) ? 8'h2E : junk[$urandom_range(0, 3)]);
    lq.push_back($urandom_range(0, 1) ? 8'h0A : 8'h0D);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic [68:0] e;
    int          k;
    forever begin
      @(negedge i_clk);
      if (i_rst && (o_start || o_error)) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_output: start=%0b error=%0b, expected no output", o_start, o_error);
        end else begin
          e = exp_q.pop_front();
          chk("out_error", 64'(o_error), 64'(e[68]));
          chk("out_start", 64'(o_start), 64'(!e[68]));
          if (o_start) begin
            chk("decimal", o_decimal, e[67:4]);
            chk("frccnt",  64'(o_frccnt), 64'(e[3:0]));
          end
          if (o_start && !e[68] && auto_finish) begin
            k = $urandom_range(1, 6);
            repeat (k) begin
              @(negedge i_clk);
              chk("wait_ready", 64'(o_ready), 64'd0);
              chk("wait_start", 64'(o_start), 64'd0);
              chk("wait_hold",  o_decimal, e[67:4]);
            end
            fin_mon = 1'b1;
            @(negedge i_clk);
            fin_mon = 1'b0;
            chk("ready_after_finish", 64'(o_ready), 64'd1);
            chk("decimal_cleared",    o_decimal, 64'd0);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  string dir[$];

  initial begin : stimulus
    int waited;
    dir = '{"123.45\n", "7\n", ".5\n", "360\n", "45\n", "1.2.3\n", "45\n", "12a\n",
            "45\n", "1234\n", "45\n", "\n", "1.000000000000\n", "1.0000000000000\n",
            "359.999\n", "0\n", ".\n", "\n", "007.1\n"};

    i_rst = 1'b0;
    repeat (3) @(negedge i_clk);
    check_reset();
    i_rst = 1'b1;
    @(negedge i_clk);

    foreach (dir[i]) send_str(dir[i]);

    // reset in the middle of a line discards it
    lq = '{8'h31, 8'h32, 8'h2E};
    send_line(1'b0);
    i_rst = 1'b0;
    #1;
    check_reset();
    @(negedge i_clk);
    i_rst = 1'b1;
    send_str("45\n");
    repeat (15) @(negedge i_clk);

    // reset during WAIT, then a stale finished pulse must be ignored
    auto_finish = 1'b0;
    send_str("9\n");
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    check_reset();
    @(negedge i_clk);
    i_rst = 1'b1;
    auto_finish = 1'b1;
    fin_main = 1'b1;
    @(negedge i_clk);
    fin_main = 1'b0;
    @(negedge i_clk);
    chk("stale_finish_ready",   64'(o_ready), 64'd1);
    chk("stale_finish_decimal", o_decimal,    64'd0);
    chk("stale_finish_start",   64'(o_start), 64'd0);
    send_str("45\n");

    repeat (150) begin
      gen_line();
      send_line(1'b1);
    end

    waited = 0;
    while (exp_q.size() != 0 && waited < 500) begin
      @(negedge i_clk);
      waited++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    repeat (20) @(negedge i_clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
